aes_output_scheduler: RTL and testbench
=======================================

// Module: aes_output_scheduler
// PURPOSE
//   Shares the byte-wide ciphertext output port between two AES engine lanes.
//   Each lane hands over a 128-bit ciphertext block through a valid/ready handshake.
//   The block arbitrates round-robin between lanes and serialises the granted block MSB-byte first.
//   Output uses a byte valid/ready handshake and ends with a per-block completion pulse.
// PARAMETERS
//   BYTES       16  bytes per block; block width is 8*BYTES
//   GAP_CYCLES  1   forced idle cycles between blocks (0..7)
// PORTS
//   clk          in   1          single clock, all state on posedge
//   rst_         in   1          asynchronous, active-high reset
//   req_valid    in   2          lane i has a block on req_block_i
//   req_block_0  in   8*BYTES    lane 0 ciphertext
//   req_block_1  in   8*BYTES    lane 1 ciphertext
//   req_ready    out  2          lane i hold register empty; accepts this cycle
//   data_out     out  8          current output byte
//   data_ok      out  1          data_out valid
//   out_ready    in   1          consumer takes byte when data_ok & out_ready
//   out_lane     out  1          lane owning the current or just-finished block
//   block_done   out  1          1-cycle pulse after the last byte is taken
// BEHAVIOUR
//   Reset values (async, rst_=1): all outputs 0 except req_ready=2'b11; holds empty; FSM IDLE; rr_last=1.
//   Capture: a lane accept happens when req_valid[i] & req_ready[i]. On that cycle the block latches
//     and hold_full[i] sets. Then req_ready[i]=~hold_full[i], registered. There is no bypass to the shifter.
//   FSM IDLE: if no hold is full, stay. If one is full, grant it. If both are full, grant ~rr_last.
//     On the grant edge: shift_reg<=hold, hold_full[g]<=0, cnt<=0, out_lane<=g, rr_last<=g, go SEND.
//   SEND: data_ok=1, data_out=shift_reg[8*BYTES-1 -: 8].
//     On each transfer: shift_reg<<=8, cnt++.
//     A transfer with cnt==BYTES-1 goes to DONE with data_ok=0 on the next cycle.
//     With no transfer, data_out and data_ok hold stable (no byte dropped or repeated).
//   DONE: block_done=1 for exactly one cycle; out_lane held.
//     Next state is GAP if GAP_CYCLES>0, else IDLE.
//   GAP: data_ok=0 for GAP_CYCLES cycles, then IDLE.
//   Latency: accept at edge k gives hold_full at k, grant at k+1, first byte valid after edge k+1.
//     With out_ready=1 throughout, block_done is high in the cycle after edge k+1+BYTES.
//   Refill: a lane freed on the grant edge shows req_ready=1 the following cycle.
//     It may load a new block while its previous block is still streaming.
//   Simultaneous: both lanes accepted in the same cycle are both stored.
//     A request arriving during SEND/DONE/GAP waits in its hold; it is never lost.
//   Reset mid-block: the partial block is discarded; no block_done is issued; both holds are cleared.
//   cnt width is $clog2(BYTES). data_out=0 whenever data_ok=0.
// CONFIGURATION
//   OSCHED_PARITY_EN defined: adds output data_par (1 bit) = ~^data_out (odd parity), valid with data_ok.
//     data_par is 0 when data_ok=0 and at reset.
//   OSCHED_PARITY_EN undefined: the data_par port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//   Package aes_osched_pkg: FSM state encoding (IDLE, SEND, DONE, GAP), LANE0/LANE1 constants,
//     and a default BLOCK_W=128.
//   Sub-module osched_hold_reg: one 8*BYTES capture register with its full flag, req_ready and a clear input.
//     It is instantiated once per lane.
//   The top level contains the arbiter, rr_last, shifter, counter and FSM.
// TESTING
//   1. Reset, then lane0 sends 00112233445566778899aabbccddeeff with out_ready=1.
//      Expect bytes 00,11,...,ff on 16 consecutive cycles, out_lane=0, and one block_done pulse.
//   2. Both lanes valid in the same cycle: lane0=A5 repeated, lane1=3C repeated.
//      After reset lane0 goes first (rr_last=1). Expect all A5 bytes, block_done, 1 gap cycle,
//      then all 3C bytes with out_lane=1.
//   3. out_ready toggles 1,0,0,1 during byte 5. data_out holds byte 5 through the stall.
//      Expect exactly 16 transfers in total and an unchanged sequence.
//   4. Lane0 refill: a second lane0 block is accepted during streaming.
//      Expect req_ready[0]=1 one cycle after the grant, and the second block to start after the gap.
//   5. rst_ pulsed after 7 bytes are taken. Expect data_ok=0 immediately and no block_done.
//      Expect req_ready=11; the next block streams from byte 0.
//   6. With OSCHED_PARITY_EN, send bytes 00,01,03: expect data_par values 1,0,1.

Source files
------------

// File: rtl/aes_osched_pkg.sv
// Shared types and constants for the AES output scheduler.
// Optional feature macro OSCHED_PARITY_EN is consumed by aes_output_scheduler.
package aes_osched_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2,
    StGap  = 2'd3
  } osched_state_e;

  localparam logic Lane0 = 1'b0;
  localparam logic Lane1 = 1'b1;

  localparam int unsigned BlockW = 128;

endpackage

// File: rtl/osched_hold_reg.sv
// Per-lane capture register: latches one block on a valid/ready accept and
// holds it until the scheduler clears it on the grant edge.
module osched_hold_reg #(
  parameter int unsigned Width = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [Width-1:0] block_i,
  input  logic             clear_i,
  output logic             ready_o,
  output logic             full_o,
  output logic [Width-1:0] data_o
);

  logic             full_d, full_q;
  logic [Width-1:0] data_d, data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear_i) begin
      full_d = 1'b0;
    end
    // Accept and clear are exclusive: accept needs empty, clear needs full.
    if (valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = block_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign ready_o = ~full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/aes_output_scheduler.sv
// Round-robin arbiter and MSB-first byte serialiser for two AES lanes.
// Define OSCHED_PARITY_EN to add the odd-parity output data_par.
module aes_output_scheduler
  import aes_osched_pkg::*;
#(
  parameter int unsigned BYTES      = BlockW / 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [1:0]         req_valid,
  input  logic [8*BYTES-1:0] req_block_0,
  input  logic [8*BYTES-1:0] req_block_1,
  output logic [1:0]         req_ready,
  output logic [7:0]         data_out,
  output logic               data_ok,
  input  logic               out_ready,
  output logic               out_lane,
  output logic               block_done
`ifdef OSCHED_PARITY_EN
  ,
  output logic               data_par
`endif
);

  localparam int unsigned BW   = 8 * BYTES;
  localparam int unsigned CntW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BYTES - 1);
  localparam logic [2:0]      GapLast = 3'(GAP_CYCLES - 1);

  osched_state_e   state_d, state_q;
  logic [BW-1:0]   shift_d, shift_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic [2:0]      gap_d, gap_q;
  logic            out_lane_d, out_lane_q;
  logic            rr_last_d, rr_last_q;

  logic [1:0]    hold_full, hold_clear;
  logic [BW-1:0] hold_data_0, hold_data_1;
  logic          grant_lane;

  osched_hold_reg #(.Width(BW)) u_hold_0 (
    .clk_i   (clk),
    .rst_i   (rst_),
    .valid_i (req_valid[0]),
    .block_i (req_block_0),
    .clear_i (hold_clear[0]),
    .ready_o (req_ready[0]),
    .full_o  (hold_full[0]),
    .data_o  (hold_data_0)
  );

  osched_hold_reg #(.Width(BW)) u_hold_1 (
    .clk_i   (clk),
    .rst_i   (rst_),
    .valid_i (req_valid[1]),
    .block_i (req_block_1),
    .clear_i (hold_clear[1]),
    .ready_o (req_ready[1]),
    .full_o  (hold_full[1]),
    .data_o  (hold_data_1)
  );

  // Both full: the lane not served last wins; otherwise whichever is full.
  always_comb begin
    if (&hold_full) begin
      grant_lane = ~rr_last_q;
    end else begin
      grant_lane = hold_full[1] ? Lane1 : Lane0;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    out_lane_d = out_lane_q;
    rr_last_d  = rr_last_q;
    hold_clear = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (|hold_full) begin
          shift_d                = (grant_lane == Lane1) ? hold_data_1 : hold_data_0;
          hold_clear[grant_lane] = 1'b1;
          cnt_d                  = '0;
          out_lane_d             = grant_lane;
          rr_last_d              = grant_lane;
          state_d                = StSend;
        end
      end
      StSend: begin
        if (out_ready) begin
          shift_d = {shift_q[BW-9:0], 8'h00};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        gap_d   = '0;
        state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
      end
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      out_lane_q <= 1'b0;
      rr_last_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      out_lane_q <= out_lane_d;
      rr_last_q  <= rr_last_d;
    end
  end

  assign data_ok    = (state_q == StSend);
  assign data_out   = data_ok ? shift_q[BW-1 -: 8] : 8'h00;
  assign block_done = (state_q == StDone);
  assign out_lane   = out_lane_q;

`ifdef OSCHED_PARITY_EN
  assign data_par = data_ok ? ~^data_out : 1'b0;
`endif

endmodule

// File: tb/tb_aes_output_scheduler.sv
// Directed, table-driven bench for aes_output_scheduler (16-byte blocks, 1 gap cycle).
module tb_aes_output_scheduler;

  logic         clk = 1'b0;
  logic         rst_;
  logic [1:0]   req_valid;
  logic [127:0] req_block_0, req_block_1;
  logic [1:0]   req_ready;
  logic [7:0]   data_out;
  logic         data_ok, out_ready, out_lane, block_done;
`ifdef OSCHED_PARITY_EN
  logic         data_par;
`endif

  aes_output_scheduler #(.BYTES(16), .GAP_CYCLES(1)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .req_valid   (req_valid),
    .req_block_0 (req_block_0),
    .req_block_1 (req_block_1),
    .req_ready   (req_ready),
    .data_out    (data_out),
    .data_ok     (data_ok),
    .out_ready   (out_ready),
    .out_lane    (out_lane),
    .block_done  (block_done)
`ifdef OSCHED_PARITY_EN
    ,
    .data_par    (data_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         lane;
    logic [127:0] blk;
    int           stall_byte;
    int           stall_len;
  } vec_t;

  vec_t vecs[4];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt, done_cyc, restart_gap;
  logic [8:0] got[$];
  logic       done_lanes[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [127:0] b, input int i);
    return b[127-8*i -: 8];
  endfunction

  task automatic clear_log();
    got.delete();
    done_lanes.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    restart_gap = -1;
  endtask

  // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (block_done) begin
      done_cnt++;
      done_lanes.push_back(out_lane);
      done_cyc = cyc;
    end
    if (data_ok && done_cyc >= 0 && restart_gap < 0) restart_gap = cyc - done_cyc;
    if (data_ok && out_ready) got.push_back({out_lane, data_out});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_      = 1'b1;
    req_valid = 2'b00;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_ = 1'b0;
  endtask

  task automatic send(input logic lane, input logic [127:0] blk);
    logic rdy;
    int   n = 0;
    if (lane) req_block_1 = blk; else req_block_0 = blk;
    req_valid[lane] = 1'b1;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      rdy = req_ready[lane];
      step();
      n++;
    end
    req_valid[lane] = 1'b0;
    check("send_accept_timeout", rdy, 1'b1);
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    check("done_timeout", done_cnt, target);
  endtask

  task automatic compare_block(input string name, input int off, input logic [127:0] blk,
                               input logic lane);
    for (int i = 0; i < 16; i++) begin
      if (off + i < got.size()) check({name, "_byte"}, got[off+i], {lane, exp_byte(blk, i)});
      else check({name, "_missing"}, off + i, got.size());
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalled = 0;
    int n = 0;
    string nm;
    nm = $sformatf("vec%0d", idx);
    clear_log();
    send(v.lane, v.blk);
    while (done_cnt == 0 && n < 100) begin
      if (got.size() == v.stall_byte && stalled < v.stall_len && data_ok) begin
        out_ready = 1'b0;
        stalled++;
        check({nm, "_stall_hold"}, data_out, exp_byte(v.blk, v.stall_byte));
      end else begin
        out_ready = 1'b1;
      end
      step();
      n++;
    end
    out_ready = 1'b1;
    check({nm, "_done"}, done_cnt, 1);
    check({nm, "_count"}, got.size(), 16);
    check({nm, "_stalls"}, stalled, v.stall_len);
    if (done_lanes.size() > 0) check({nm, "_done_lane"}, done_lanes[0], v.lane);
    compare_block(nm, 0, v.blk, v.lane);
  endtask

  initial begin
    logic [127:0] blk_a, blk_b;
    int n;

    vecs[0] = '{1'b1, 128'hfedcba98765432100123456789abcdef, -1, 0};
    vecs[1] = '{1'b0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 5, 2};
    vecs[2] = '{1'b1, 128'h55aa55aa00ff00ff123456789abcdef0, 15, 3};
    vecs[3] = '{1'b0, 128'h800000000000000000000000000000c1, 1, 1};

    req_block_0 = '0;
    req_block_1 = '0;
    req_valid   = 2'b00;
    out_ready   = 1'b1;
    rst_        = 1'b1;
    clear_log();
    #3;
    check("reset_req_ready", req_ready, 2'b11);
    check("reset_data_ok", data_ok, 1'b0);
    check("reset_data_out", data_out, 8'h00);
    check("reset_out_lane", out_lane, 1'b0);
    check("reset_block_done", block_done, 1'b0);
`ifdef OSCHED_PARITY_EN
    check("reset_data_par", data_par, 1'b0);
`endif
    @(posedge clk);
    #1;
    rst_ = 1'b0;

    // Single block on lane 0 with latency and pulse-width checks.
    blk_a = 128'h00112233445566778899aabbccddeeff;
    clear_log();
    send(1'b0, blk_a);
    check("t1_hold_full", req_ready, 2'b10);
    step();
    check("t1_first_ok", data_ok, 1'b1);
    check("t1_first_byte", data_out, 8'h00);
    check("t1_lane", out_lane, 1'b0);
    check("t1_refill_ready", req_ready, 2'b11);
    n = 1;
    while (!block_done && n < 40) begin
      step();
      n++;
    end
    check("t1_done_latency", n, 17);
    check("t1_done_data_ok", data_ok, 1'b0);
    step();
    check("t1_done_pulse", block_done, 1'b0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_count", got.size(), 16);
    compare_block("t1", 0, blk_a, 1'b0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Both lanes at once after reset: lane 0 wins first.
    do_reset();
    clear_log();
    blk_a       = {16{8'ha5}};
    blk_b       = {16{8'h3c}};
    req_block_0 = blk_a;
    req_block_1 = blk_b;
    req_valid   = 2'b11;
    step();
    req_valid = 2'b00;
    check("t2_both_held", req_ready, 2'b00);
    run_until(2, 80);
    check("t2_count", got.size(), 32);
    compare_block("t2a", 0, blk_a, 1'b0);
    compare_block("t2b", 16, blk_b, 1'b1);
    if (done_lanes.size() == 2) begin
      check("t2_done_lane0", done_lanes[0], 1'b0);
      check("t2_done_lane1", done_lanes[1], 1'b1);
    end
    check("t2_restart_gap", restart_gap, 3);

    // Lane 0 refill while its previous block streams.
    clear_log();
    blk_a = 128'h102132435465768798a9bacbdcedfe0f;
    blk_b = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
    send(1'b0, blk_a);
    step();
    check("t4_refill_ready", req_ready[0], 1'b1);
    send(1'b0, blk_b);
    check("t4_refill_full", req_ready[0], 1'b0);
    run_until(2, 80);
    check("t4_count", got.size(), 32);
    compare_block("t4a", 0, blk_a, 1'b0);
    compare_block("t4b", 16, blk_b, 1'b0);
    check("t4_restart_gap", restart_gap, 3);

    // Reset in the middle of a block, with lane 1 also waiting.
    clear_log();
    blk_a = 128'h0102030405060708090a0b0c0d0e0f10;
    send(1'b0, blk_a);
    send(1'b1, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
    n = 0;
    while (got.size() < 7 && n < 40) begin
      step();
      n++;
    end
    check("t5_taken", got.size(), 7);
    rst_ = 1'b1;
    #1;
    check("t5_rst_data_ok", data_ok, 1'b0);
    check("t5_rst_data_out", data_out, 8'h00);
    check("t5_rst_done", block_done, 1'b0);
    check("t5_rst_ready", req_ready, 2'b11);
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    clear_log();
    for (int i = 0; i < 25; i++) step();
    check("t5_no_done", done_cnt, 0);
    check("t5_no_bytes", got.size(), 0);
    run_vec('{1'b0, 128'h99887766554433221100ffeeddccbbaa, -1, 0}, 9);

`ifdef OSCHED_PARITY_EN
    clear_log();
    send(1'b0, 128'h00010300000000000000000000000000);
    step();
    check("par_byte0", data_par, 1'b1);
    step();
    check("par_byte1", data_par, 1'b0);
    step();
    check("par_byte2", data_par, 1'b1);
    run_until(1, 40);
    check("par_idle", data_par, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
